// File: rtl/uart_rx_fifo_param_if.sv
// Read-side port of the parametrised UART receiver: FWFT FIFO head, status and pop/clear strobes.
interface uart_rx_fifo_param_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic              Unload_data;
    logic              Clear_overrun;
    logic [DATA_W-1:0] RX_data;
    logic              Frame_error;
    logic              Parity_error;
    logic              Empty;
    logic              Full;
    logic [CNT_W-1:0]  Count;
    logic              Overrun;

    modport master (
        input  Unload_data, Clear_overrun,
        output RX_data, Frame_error, Parity_error, Empty, Full, Count, Overrun
    );

    modport slave (
        output Unload_data, Clear_overrun,
        input  RX_data, Frame_error, Parity_error, Empty, Full, Count, Overrun
    );
endinterface

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receiver: 3-sample majority vote, 5..9 data bits, optional parity,
// 1 or 2 stop bits, completed frames with error flags queued in a first-word-fall-through FIFO.
module uart_rx_fifo_param #(
    parameter int DATA_W      = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  Enable,
    input  logic                  baud_tick,
    input  logic [1:0]            Parity_mode,
    input  logic                  Two_stop,
    input  logic                  UART_RX_I,
    uart_rx_fifo_param_if.master  rx
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = DATA_W + 2;
    localparam logic [TICK_W-1:0] SMP0     = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] SMP1     = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] SMP2     = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] LAST     = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // Stage: asynchronous pin into the Clk domain; idle line level is 1
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge Clk) begin
        if (!Resetn) sync_q <= '1;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RX_I};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Stage p0 samples / p1 vote / p2 push: frame engine
    state_t             state_q;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [2:0]         smp_p0;
    logic               vote_vld_p1;
    logic               vote;
    logic               wrap;
    logic [DATA_W-1:0]  shift_q;
    logic [1:0]         par_mode_q;
    logic               two_stop_q;
    logic               frame_err_q;
    logic               parity_err_q;
    logic               push_vld_p2;
    logic [ENT_W-1:0]   push_ent_p2;

    assign vote = maj3(smp_p0);
    assign wrap = baud_tick && (tick_cnt == LAST);

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q      <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            vote_vld_p1  <= 1'b0;
            par_mode_q   <= 2'b00;
            two_stop_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            push_vld_p2  <= 1'b0;
        end else begin
            push_vld_p2 <= 1'b0;
            vote_vld_p1 <= 1'b0;
            if (baud_tick) begin
                tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
                if (tick_cnt == SMP0) smp_p0[0] <= rx_s;
                if (tick_cnt == SMP1) smp_p0[1] <= rx_s;
                if (tick_cnt == SMP2) begin
                    smp_p0[2]   <= rx_s;
                    vote_vld_p1 <= (state_q != IDLE);
                end
            end
            if (state_q != IDLE && !Enable) begin
                state_q     <= IDLE;
                vote_vld_p1 <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (Enable && !rx_s) begin
                        state_q      <= START;
                        tick_cnt     <= '0;
                        vote_vld_p1  <= 1'b0;
                        par_mode_q   <= Parity_mode;
                        two_stop_q   <= Two_stop;
                        frame_err_q  <= 1'b0;
                        parity_err_q <= 1'b0;
                    end
                    START: begin
                        if (vote_vld_p1 && vote) state_q <= IDLE;
                        else if (wrap) begin
                            state_q <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (vote_vld_p1) shift_q <= {vote, shift_q[DATA_W-1:1]};
                        if (wrap) begin
                            if (bit_cnt == LAST_BIT) state_q <= (^par_mode_q) ? PARITY : STOP1;
                            else                     bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        // par_mode_q[1] is 1 only for odd parity
                        if (vote_vld_p1) parity_err_q <= (^shift_q) ^ vote ^ par_mode_q[1];
                        if (wrap) state_q <= STOP1;
                    end
                    STOP1: begin
                        if (vote_vld_p1) begin
                            if (!vote) frame_err_q <= 1'b1;
                            if (!two_stop_q) begin
                                push_vld_p2 <= 1'b1;
                                push_ent_p2 <= {shift_q, frame_err_q | ~vote, parity_err_q};
                                state_q     <= IDLE;
                            end
                        end else if (wrap && two_stop_q) begin
                            state_q <= STOP2;
                        end
                    end
                    STOP2: if (vote_vld_p1) begin
                        frame_err_q <= frame_err_q | ~vote;
                        push_vld_p2 <= 1'b1;
                        push_ent_p2 <= {shift_q, frame_err_q | ~vote, parity_err_q};
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Stage: receive FIFO, head read combinationally for fall-through
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overrun_q;
    logic             full, empty, do_pop, do_push, drop;
    logic [ENT_W-1:0] head;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = rx.Unload_data && !empty;
    assign do_push = push_vld_p2 && (!full || do_pop);
    assign drop    = push_vld_p2 && full && !do_pop;

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= push_ent_p2;
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
            // a drop in the same cycle as a clear leaves the flag set
            if (drop)                   overrun_q <= 1'b1;
            else if (rx.Clear_overrun)  overrun_q <= 1'b0;
        end
    end

    assign head            = empty ? '0 : mem[rd_ptr];
    assign rx.RX_data      = head[ENT_W-1:2];
    assign rx.Frame_error  = head[1];
    assign rx.Parity_error = head[0];
    assign rx.Empty        = empty;
    assign rx.Full         = full;
    assign rx.Count        = count_q;
    assign rx.Overrun      = overrun_q;
endmodule
